// File: rtl/register_file_reader.sv
// Read-side sequencer: walks r_addr over a window of a register_file and streams
// each word on valid/ready. Optional checksum port: REGISTER_FILE_READER_CHECKSUM_EN.
module register_file_reader #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR-1:0]   base_addr,
    input  logic [ADDR:0]     count,
    output logic [ADDR-1:0]   r_addr,
    input  logic [WIDTH-1:0]  r_data,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]  checksum
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | r_addr stable, r_data captured at the edge
    // SEND   | out_valid high, waiting for handshake
    // DONE   | one-cycle done pulse
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR:0]   ONE_R = 1;
    localparam logic [ADDR-1:0] ONE_A = 1;

    state_t            state_q, state_d;
    logic [ADDR-1:0]   r_addr_q, r_addr_d;
    logic [ADDR:0]     remaining_q, remaining_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
    logic [WIDTH-1:0]  checksum_q, checksum_d;
`endif

    always_comb begin
        state_d     = state_q;
        r_addr_d    = r_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (count != '0) begin
                        r_addr_d    = base_addr;
                        remaining_d = count;
                        busy_d      = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                out_data_d  = r_data;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    remaining_d = remaining_q - ONE_R;
                    out_valid_d = 1'b0;
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
                    checksum_d  = checksum_q + out_data_q;
`endif
                    if (remaining_q == ONE_R) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // address wraps naturally at 2**ADDR
                        r_addr_d = r_addr_q + ONE_A;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_addr_q    <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            r_addr_q    <= r_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign r_addr    = r_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef REGISTER_FILE_READER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule
